uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial UART receiver: 8N1 frames (8E1 with the optional feature) on one input pin.
- Produces one byte plus a one-cycle valid strobe per good frame.
- Sits directly upstream of the GPIO register: rx_data drives its write data, rx_valid drives its write enable.
- The GPIO, PWM and 7-segment path can therefore be loaded from a host serial link instead of parallel pins.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.

Ports:
clk         input   1  system clock; all logic on the rising edge
rst         input   1  synchronous, active-high reset
rx_in       input   1  asynchronous serial line, idle high
rx_data     output  8  last correctly received byte, LSB received first
rx_valid    output  1  one-cycle pulse: rx_data updated this cycle
busy        output  1  high whenever the FSM is not in IDLE
frame_err   output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without PARITY_EN)

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - Internals: FSM=IDLE, both synchronizer flops=1, bit counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame with no strobe.
- Synchronizer:
  - rx_in passes through 2 flops to give rx_s.
  - All decisions use rx_s only, so line-to-decision latency is 2 cycles.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state change.
  - Increments each cycle otherwise.
- FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP, WAIT_IDLE.
- IDLE: rx_s==0 -> START, counter=0.
- START: at counter==CLKS_PER_BIT/2-1 (integer divide):
  - rx_s==0 -> DATA; this mid-bit point becomes the sample phase for every later bit.
  - rx_s==1 -> IDLE (glitch reject); no strobes.
- DATA: at counter==CLKS_PER_BIT-1:
  - Shift rx_s into shift[7] and shift the register right.
  - Increment bit index.
  - After the 8th sample -> PARITY if enabled, else STOP.
  - Bit index resets to 0 on leaving DATA.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1 and no parity error: rx_data<=shift, rx_valid=1 for exactly the next cycle -> IDLE.
  - rx_s==1 with parity error: parity_err=1 for one cycle, rx_data unchanged, no rx_valid -> IDLE.
  - rx_s==0: frame_err=1 for one cycle, rx_data unchanged, no rx_valid -> WAIT_IDLE.
  - If the stop bit is low and parity is also bad, only frame_err is raised.
- WAIT_IDLE (break or line stuck low):
  - Stay until rx_s==1, then -> IDLE.
  - No new start bit is recognised until the line has returned high.
- Strobe rules:
  - rx_valid, frame_err and parity_err are mutually exclusive and never high for two consecutive cycles.
  - rx_data holds its value between valid pulses.
- Back-to-back frames:
  - The FSM returns to IDLE mid-stop-bit.
  - A start edge arriving immediately after a single stop bit is accepted with no lost frame.
- Timing: rx_valid is asserted 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx_in falling edge (8N1), ±1 cycle for synchronizer phase.
- No flow control: a consumer that misses the pulse loses the byte. The GPIO register samples every cycle, so it never misses one.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state sits between DATA and STOP.
  - One bit is sampled at counter==CLKS_PER_BIT-1.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch is latched and reported at STOP as above.
  - Frame length is 11 bits, so rx_valid latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state, 10-bit frames.
  - parity_err tied to 0.

Test Plan:
All tests use CLKS_PER_BIT=16 and a 16-cycle bit period unless noted.
1. Send 8N1 byte 0xA5 -> exactly one rx_valid pulse, rx_data=0xA5, busy high from start detect to pulse, frame_err=0; pulse time within ±1 of formula (2+8+144+1=155 cycles).
2. Drive rx_in low for 5 cycles then high -> no strobes, FSM back to IDLE; then send 0x3C -> rx_valid with rx_data=0x3C.
3. Send 0x81 with stop bit low, then hold the line low for 40 cycles -> frame_err single pulse, rx_data keeps its prior value, busy stays high until the line goes high; then send 0x7E -> rx_valid, rx_data=0x7E.
4. Send 0x00 then 0xFF back-to-back with single stop bits -> two rx_valid pulses with rx_data 0x00 then 0xFF, no errors.
5. Assert rst for 1 cycle during data bit 4 of a frame -> all outputs 0 next cycle, no strobe for that frame; next full frame 0x55 is received correctly.
6. With UART_RX_PARITY_EN defined:
   - 0x03 with parity bit 0 -> rx_valid, rx_data=0x03.
   - 0x07 with parity bit 0 -> parity_err pulse, no rx_valid, rx_data remains 0x03.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: one byte and a one-cycle strobe per good frame.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          par_bad_q, par_bad_d;
   logic          mid_tick, bit_tick;

   assign mid_tick = (cnt_q == HALF);
   assign bit_tick = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= rx_in;
         rx_s_q    <= sync1_q;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         S_START: if (mid_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA: begin
            if (bit_tick && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
         S_PARITY: if (bit_tick) state_d = S_STOP;
         // Leave mid-stop-bit so a back-to-back start edge is not missed
         S_STOP:   if (bit_tick) state_d = rx_s_q ? S_IDLE : S_WAIT;
         S_WAIT:   if (rx_s_q) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      par_bad_d = par_bad_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;
      if (state_d != state_q || bit_tick || state_q == S_IDLE)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            bit_idx_d = '0;
            par_bad_d = 1'b0;
         end
         S_DATA: begin
            if (bit_tick) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (bit_tick) par_bad_d = (^shift_q) ^ rx_s_q;
`endif
         S_STOP: begin
            if (bit_tick) begin
               if (!rx_s_q)
                  ferr_d = 1'b1;
               else if (par_bad_q)
                  perr_d = 1'b1;
               else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_byte;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, parity_err;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .frame_err (frame_err),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_valid = 0, n_ferr = 0, n_perr = 0, viol = 0, valid_cyc = 0;
   logic [7:0] got_q[$];
   logic       pv = 1'b0, pf = 1'b0, pp = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         valid_cyc = cyc;
         got_q.push_back(rx_data);
      end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) viol++;
      if ((rx_valid && pv) || (frame_err && pf) || (parity_err && pp)) viol++;
      pv = rx_valid;
      pf = frame_err;
      pp = parity_err;
   end

   int checks = 0, failures = 0;
   int fall_cyc = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic par);
      fall_cyc = cyc;
      rx_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx_in = par;
      repeat (CPB) @(negedge clk);
`else
      if (par) rx_in = 1'b0;
`endif
      rx_in = stop;
      repeat (CPB) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       bad_par;
      int         hold_low;
      int         e_valid;
      int         e_ferr;
      int         e_perr;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int nv, nf, np, qs, lat;
      logic [7:0] g0, g1;

      tbl.push_back('{8'hA5, 1'b1, 1'b0, 0, 1, 0, 0, 8'hA5});
      tbl.push_back('{8'h3C, 1'b1, 1'b0, 0, 1, 0, 0, 8'h3C});
      tbl.push_back('{8'h81, 1'b0, 1'b0, 40, 0, 1, 0, 8'h3C});
      tbl.push_back('{8'h7E, 1'b1, 1'b0, 0, 1, 0, 0, 8'h7E});
`ifdef UART_RX_PARITY_EN
      tbl.push_back('{8'h03, 1'b1, 1'b0, 0, 1, 0, 0, 8'h03});
      tbl.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 0, 1, 8'h03});
      tbl.push_back('{8'hC1, 1'b0, 1'b1, 20, 0, 1, 0, 8'h03});
`endif

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_perr", parity_err, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         nv = n_valid;
         nf = n_ferr;
         np = n_perr;
         send_frame(tbl[i].d, tbl[i].stop, (^tbl[i].d) ^ tbl[i].bad_par);
         if (i == 0) begin
            lat = valid_cyc - fall_cyc;
            check("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
         end
         if (tbl[i].hold_low > 0) begin
            repeat (tbl[i].hold_low) @(negedge clk);
            check("busy_line_low", busy, 1);
         end
         rx_in = 1'b1;
         repeat (2 * CPB) @(negedge clk);
         check($sformatf("v%0d_valid", i), n_valid - nv, tbl[i].e_valid);
         check($sformatf("v%0d_ferr", i), n_ferr - nf, tbl[i].e_ferr);
         check($sformatf("v%0d_perr", i), n_perr - np, tbl[i].e_perr);
         check($sformatf("v%0d_data", i), rx_data, tbl[i].e_data);
         check($sformatf("v%0d_idle", i), busy, 0);
      end

      // Short low glitch must be rejected at the start-bit midpoint
      nv = n_valid;
      nf = n_ferr;
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch_busy", busy, 1);
      @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_idle", busy, 0);
      check("glitch_nostrobe", (n_valid - nv) + (n_ferr - nf), 0);
      send_frame(8'h3C, 1'b1, 1'b0);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_next_valid", n_valid - nv, 1);
      check("glitch_next_data", rx_data, 8'h3C);

      // Back-to-back frames with a single stop bit
      nv = n_valid;
      nf = n_ferr;
      qs = got_q.size();
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      g0 = (got_q.size() > qs) ? got_q[qs] : 8'hEE;
      g1 = (got_q.size() > qs + 1) ? got_q[qs+1] : 8'hEE;
      check("b2b_count", n_valid - nv, 2);
      check("b2b_first", g0, 8'h00);
      check("b2b_second", g1, 8'hFF);
      check("b2b_ferr", n_ferr - nf, 0);

      // Reset during data bit 4 aborts the frame
      nv = n_valid;
      nf = n_ferr;
      np = n_perr;
      rx_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_in = i[0] ? 1'b0 : 1'b1;
         repeat (CPB) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data", rx_data, 8'h00);
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ferr", frame_err, 0);
      repeat (12 * CPB) @(negedge clk);
      check("mid_rst_nostrobe", (n_valid - nv) + (n_ferr - nf) + (n_perr - np), 0);
      send_frame(8'h55, 1'b1, 1'b0);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("post_rst_valid", n_valid - nv, 1);
      check("post_rst_data", rx_data, 8'h55);

      check("strobe_rules", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
